// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and constants for the serial CRC engine
package crc_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

   localparam logic [15:0] CRC16_CCITT = 16'h1021;
   localparam logic [7:0]  CRC8_ATM    = 8'h07;

   // Bit counter must stay at least one bit wide even for single-bit words
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crc_serial_xor_if.sv
// rtl/crc_serial_xor_if.sv - message-in / crc-out handshake bundle
interface crc_serial_xor_if #(
   parameter int DATA_W = 8,
   parameter int CRC_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [CRC_W-1:0]  out_crc;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_crc
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_crc
   );
endinterface

// File: rtl/crc_lfsr_step.sv
// rtl/crc_lfsr_step.sv - one combinational XOR-feedback LFSR step
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_CCITT)
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic             data_bit,
   output logic [CRC_W-1:0] crc_out
);
   logic fb;

   assign fb      = crc_in[CRC_W-1] ^ data_bit;
   assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
endmodule

// File: rtl/crc_serial_xor.sv
// rtl/crc_serial_xor.sv - bit-serial CRC engine, one message bit per clock
module crc_serial_xor
   import crc_pkg::*;
#(
   parameter int               DATA_W  = 8,
   parameter int               CRC_W   = 16,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_CCITT),
   parameter logic [CRC_W-1:0] INIT    = CRC_W'(16'hFFFF),
   parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(16'h0000)
) (
   input  logic       clk,
   input  logic       rst_n,
   crc_serial_xor_if.slave bus,
   output logic       busy
);
   localparam int CNT_W = cnt_width(DATA_W);

   state_t            state, state_nxt;
   logic [CRC_W-1:0]  crc_reg, crc_step;
   logic [DATA_W-1:0] shift_reg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              last_q;
   logic              accept;
   logic              last_bit;

   assign accept   = bus.in_valid & bus.in_ready;
   assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

   crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
      .crc_in   (crc_reg),
      .data_bit (shift_reg[DATA_W-1]),
      .crc_out  (crc_step)
   );

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_bit) state_nxt = last_q ? DONE : WAIT;
         end
         WAIT: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = SHIFT;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         crc_reg   <= INIT;
         shift_reg <= '0;
         bit_cnt   <= '0;
         last_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // Only a fresh message reseeds; words accepted in WAIT keep folding in
            if (state == IDLE) crc_reg <= INIT;
            shift_reg <= bus.in_data;
            last_q    <= bus.in_last;
            bit_cnt   <= '0;
         end else if (state == SHIFT) begin
            crc_reg   <= crc_step;
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.out_crc = crc_reg ^ XOR_OUT;
   assign busy        = (state != IDLE);
endmodule
